// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage next-PC logic: address width,
// redirect source encodings and the PC register reset value.
package pc_pkg;

    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        PC_SEL_INT    = 2'b00,
        PC_SEL_STACK  = 2'b01,
        PC_SEL_BRANCH = 2'b10,
        PC_SEL_RESET  = 2'b11
    } pc_sel_e;

    localparam logic [ADDR_W-1:0] PC_RESET_VAL = 8'h00;

endpackage

// File: rtl/pc_reg.sv
// Purpose: ADDR_W-wide PC holding register with load enable and async clear.
// Latency: one cycle from d to q when en=1.
// Backpressure: en=0 stalls; q holds and the offered d is dropped.
module pc_reg #(
    parameter int                ADDR_W  = 8,
    parameter logic [ADDR_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (en) begin
            pc_d = d;
        end
    end

    // Clear is independent of clk so the fetch address drops the moment reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RST_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign q = pc_q;

endmodule

// File: rtl/pc_new_unit.sv
// Purpose: next-PC mux (sequential/interrupt/stack/branch/reset) plus PC register.
// Latency: pc_new is combinational; pc follows pc_new one edge later when pc_en=1.
// Backpressure: pc_en=0 holds pc; a redirect offered during a stall is not remembered.
module pc_new_unit
    import pc_pkg::*;
#(
    parameter int ADDR_W = pc_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_en,
    input  logic              pc_src,
    input  logic [1:0]        pc_in_sel,
    input  logic [ADDR_W-1:0] pc_plus_1,
    input  logic [ADDR_W-1:0] stack_addr,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic [ADDR_W-1:0] reset_addr,
    input  logic [ADDR_W-1:0] interrupt_addr,
    output logic [ADDR_W-1:0] pc_new,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] redirect_addr;
    logic [ADDR_W-1:0] pc_new_d;

    // Every encoding maps to exactly one source; there is no priority between them.
    always_comb begin
        redirect_addr = interrupt_addr;
        case (pc_sel_e'(pc_in_sel))
            PC_SEL_INT:    redirect_addr = interrupt_addr;
            PC_SEL_STACK:  redirect_addr = stack_addr;
            PC_SEL_BRANCH: redirect_addr = branch_addr;
            PC_SEL_RESET:  redirect_addr = reset_addr;
        endcase
    end

    // Wrap of the sequential address is the incrementer's job; pass it through untouched.
    always_comb begin
        pc_new_d = pc_plus_1;
        if (pc_src) begin
            pc_new_d = redirect_addr;
        end
    end

    assign pc_new = pc_new_d;

    pc_reg #(
        .ADDR_W  (ADDR_W),
        .RST_VAL (ADDR_W'(PC_RESET_VAL))
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_en),
        .d     (pc_new_d),
        .q     (pc)
    );

endmodule

// File: tb/tb_pc_new_unit.sv
// Bench for pc_new_unit: directed literal checks followed by randomized traffic
// compared every cycle against a behavioural next-PC / PC model.
module tb_pc_new_unit;

    logic       clk;
    logic       rst_n;
    logic       pc_en;
    logic       pc_src;
    logic [1:0] pc_in_sel;
    logic [7:0] pc_plus_1;
    logic [7:0] stack_addr;
    logic [7:0] branch_addr;
    logic [7:0] reset_addr;
    logic [7:0] interrupt_addr;
    logic [7:0] pc_new;
    logic [7:0] pc;

    int   n_cmp;
    int   n_bad;
    bit   chk_en;
    logic [7:0] exp_pc;

    pc_new_unit #(.ADDR_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_en          (pc_en),
        .pc_src         (pc_src),
        .pc_in_sel      (pc_in_sel),
        .pc_plus_1      (pc_plus_1),
        .stack_addr     (stack_addr),
        .branch_addr    (branch_addr),
        .reset_addr     (reset_addr),
        .interrupt_addr (interrupt_addr),
        .pc_new         (pc_new),
        .pc             (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a table of the four redirect targets indexed by the select code.
    function automatic logic [7:0] ref_new();
        logic [7:0] tgt [4];
        tgt[0] = interrupt_addr;
        tgt[1] = stack_addr;
        tgt[2] = branch_addr;
        tgt[3] = reset_addr;
        return pc_src ? tgt[pc_in_sel] : pc_plus_1;
    endfunction

    initial exp_pc = 8'h00;

    always @(posedge clk) begin
        if (!rst_n)     exp_pc = 8'h00;
        else if (pc_en) exp_pc = ref_new();
    end

    always @(negedge rst_n) exp_pc = 8'h00;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pc_new", pc_new, ref_new());
            check("model_pc", pc, exp_pc);
        end
    end

    task automatic drive(input logic src, input logic [1:0] sel, input logic [7:0] p1,
                         input logic [7:0] st, input logic [7:0] br, input logic [7:0] rv,
                         input logic [7:0] iv, input logic en);
        pc_src         = src;
        pc_in_sel      = sel;
        pc_plus_1      = p1;
        stack_addr     = st;
        branch_addr    = br;
        reset_addr     = rv;
        interrupt_addr = iv;
        pc_en          = en;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        drive(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        #1 chk_en = 1'b1;
        next_edge();
        next_edge();
        check("reset_pc", pc, 8'h00);
        rst_n = 1'b1;

        // Sequential flow, including the 0x00 wrap value passing through.
        drive(1'b0, 2'b00, 8'h10, 8'h20, 8'h30, 8'h40, 8'hFF, 1'b1);
        #1 check("seq_pc_new", pc_new, 8'h10);
        next_edge();
        check("seq_pc", pc, 8'h10);

        drive(1'b1, 2'b00, 8'h10, 8'h20, 8'h30, 8'h40, 8'hFF, 1'b0);
        #1 check("int_pc_new", pc_new, 8'hFF);
        pc_in_sel = 2'b01;
        #1 check("stack_pc_new", pc_new, 8'h20);
        pc_in_sel = 2'b10;
        #1 check("branch_pc_new", pc_new, 8'h30);
        pc_in_sel = 2'b11;
        #1 check("resetvec_pc_new", pc_new, 8'h40);
        pc_src    = 1'b0;
        pc_plus_1 = 8'h55;
        #1 check("seq_ignores_sel", pc_new, 8'h55);
        pc_plus_1 = 8'h00;
        #1 check("seq_wrap_zero", pc_new, 8'h00);

        // Stall with a branch pending: pc must hold, then load once enabled.
        drive(1'b1, 2'b10, 8'h11, 8'h20, 8'h30, 8'h40, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            next_edge();
            check("stall_hold", pc, 8'h10);
        end
        check("stall_pc_new", pc_new, 8'h30);
        pc_en = 1'b1;
        next_edge();
        check("stall_release", pc, 8'h30);

        // Reset dropped between edges clears pc without a clock edge.
        pc_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_clear", pc, 8'h00);
        check("pc_new_in_reset", pc_new, 8'h30);
        pc_en = 1'b1;
        next_edge();
        check("reset_discards_load", pc, 8'h00);
        drive(1'b1, 2'b11, 8'h01, 8'h20, 8'h30, 8'h40, 8'hFF, 1'b1);
        rst_n = 1'b1;
        next_edge();
        check("load_reset_vector", pc, 8'h40);

        // Randomized traffic with occasional mid-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            drive(1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 63) == 0) begin
                #2 rst_n = 1'b0;
            end
        end
        rst_n = 1'b1;
        next_edge();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
